// File: rtl/scene_composer.sv
`timescale 1ns/1ps
// Per-pixel scene lookup: classifies each scan pixel as bullet, tank, wall or background.
// Latency: addr at +2 edges, tank_direct/player_tank at +3, category at +4 from the pixel edge.
// Backpressure: none; accepts one pixel per clock with fixed latency, no valid/stall.
//
// Ports:
//   clk, rst                    pixel clock, synchronous active-high reset
//   pixel_x, pixel_y            current scan coordinate
//   frame_commit                copy shadow object table to live table
//   tank_we/idx/x/y/dir/en      tank shadow slot write
//   bullet_we/idx/x/y/en        bullet shadow slot write
//   wall_we/col/row/val         wall map write (not shadowed)
//   category                    NONE=0, WALL=1, TANK=2, BULLET=3
//   addr                        tank sprite ROM address (row*32+col)
//   tank_direct, player_tank    covering tank's direction and slot-0 flag
module scene_composer #(
   parameter int TANK_N      = 4,
   parameter int BULLET_N    = 8,
   parameter int TANK_SIZE   = 32,
   parameter int BULLET_SIZE = 4,
   parameter int TILE        = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic       frame_commit,
   input  logic       tank_we,
   input  logic [1:0] tank_idx,
   input  logic [9:0] tank_x,
   input  logic [9:0] tank_y,
   input  logic [2:0] tank_dir,
   input  logic       tank_en,
   input  logic       bullet_we,
   input  logic [2:0] bullet_idx,
   input  logic [9:0] bullet_x,
   input  logic [9:0] bullet_y,
   input  logic       bullet_en,
   input  logic       wall_we,
   input  logic [4:0] wall_col,
   input  logic [4:0] wall_row,
   input  logic       wall_val,
   output logic [3:0] category,
   output logic [9:0] addr,
   output logic [2:0] tank_direct,
   output logic       player_tank
);

   localparam logic [3:0]  CAT_NONE   = 4'd0;
   localparam logic [3:0]  CAT_WALL   = 4'd1;
   localparam logic [3:0]  CAT_TANK   = 4'd2;
   localparam logic [3:0]  CAT_BULLET = 4'd3;
   localparam logic [10:0] TSZ        = 11'(TANK_SIZE);
   localparam logic [10:0] BSZ        = 11'(BULLET_SIZE);
   localparam logic [9:0]  TILE_W     = 10'(TILE);

   // ---------------- object tables (shadow + live) ----------------
   logic [9:0] sh_tx [TANK_N];
   logic [9:0] sh_ty [TANK_N];
   logic [2:0] sh_td [TANK_N];
   logic       sh_te [TANK_N];
   logic [9:0] lv_tx [TANK_N];
   logic [9:0] lv_ty [TANK_N];
   logic [2:0] lv_td [TANK_N];
   logic       lv_te [TANK_N];
   logic [9:0] sh_bx [BULLET_N];
   logic [9:0] sh_by [BULLET_N];
   logic       sh_be [BULLET_N];
   logic [9:0] lv_bx [BULLET_N];
   logic [9:0] lv_by [BULLET_N];
   logic       lv_be [BULLET_N];

   // Non-blocking semantics give the required ordering: a commit in the same
   // cycle as a shadow write copies the old shadow contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TANK_N; i++) begin
            sh_tx[i] <= '0; sh_ty[i] <= '0; sh_td[i] <= '0; sh_te[i] <= 1'b0;
            lv_tx[i] <= '0; lv_ty[i] <= '0; lv_td[i] <= '0; lv_te[i] <= 1'b0;
         end
         for (int j = 0; j < BULLET_N; j++) begin
            sh_bx[j] <= '0; sh_by[j] <= '0; sh_be[j] <= 1'b0;
            lv_bx[j] <= '0; lv_by[j] <= '0; lv_be[j] <= 1'b0;
         end
      end else begin
         if (frame_commit) begin
            for (int i = 0; i < TANK_N; i++) begin
               lv_tx[i] <= sh_tx[i]; lv_ty[i] <= sh_ty[i];
               lv_td[i] <= sh_td[i]; lv_te[i] <= sh_te[i];
            end
            for (int j = 0; j < BULLET_N; j++) begin
               lv_bx[j] <= sh_bx[j]; lv_by[j] <= sh_by[j]; lv_be[j] <= sh_be[j];
            end
         end
         if (tank_we) begin
            sh_tx[tank_idx] <= tank_x;
            sh_ty[tank_idx] <= tank_y;
            sh_td[tank_idx] <= tank_dir;
            sh_te[tank_idx] <= tank_en;
         end
         if (bullet_we) begin
            sh_bx[bullet_idx] <= bullet_x;
            sh_by[bullet_idx] <= bullet_y;
            sh_be[bullet_idx] <= bullet_en;
         end
      end
   end

   // ---------------- wall map ----------------
   // 32 rows are stored so any 5-bit row index is in range; rows 24..31 are
   // never written and are only read for off-screen pixels, which are masked.
   logic [31:0] wall_map [32];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 32; r++) wall_map[r] <= '0;
      end else if (wall_we && (wall_row < 5'd24)) begin
         wall_map[wall_row][wall_col] <= wall_val;
      end
   end

   // ---------------- stage 1: hit tests against the live table ----------------
   logic [10:0]         px11, py11;
   logic                in_b;
   logic [4:0]          w_col, w_row;
   logic [TANK_N-1:0]   t_hit;
   logic [BULLET_N-1:0] b_hit;
   logic [4:0]          t_rx [TANK_N];
   logic [4:0]          t_ry [TANK_N];

   assign px11  = {1'b0, pixel_x};
   assign py11  = {1'b0, pixel_y};
   assign in_b  = (pixel_x < 10'd640) && (pixel_y < 10'd480);
   assign w_col = 5'(pixel_x / TILE_W);
   assign w_row = 5'(pixel_y / TILE_W);

   always_comb begin
      for (int i = 0; i < TANK_N; i++) begin
         t_hit[i] = lv_te[i]
                    && (px11 >= {1'b0, lv_tx[i]}) && (px11 < ({1'b0, lv_tx[i]} + TSZ))
                    && (py11 >= {1'b0, lv_ty[i]}) && (py11 < ({1'b0, lv_ty[i]} + TSZ));
         // Only the low 5 bits matter: the offset is < 32 whenever the tank hits.
         t_rx[i] = 5'(pixel_x - lv_tx[i]);
         t_ry[i] = 5'(pixel_y - lv_ty[i]);
      end
      for (int j = 0; j < BULLET_N; j++) begin
         b_hit[j] = lv_be[j]
                    && (px11 >= {1'b0, lv_bx[j]}) && (px11 < ({1'b0, lv_bx[j]} + BSZ))
                    && (py11 >= {1'b0, lv_by[j]}) && (py11 < ({1'b0, lv_by[j]} + BSZ));
      end
   end

   logic              s1_inb, s1_bhit, s1_whit;
   logic [TANK_N-1:0] s1_thit;
   logic [4:0]        s1_rx  [TANK_N];
   logic [4:0]        s1_ry  [TANK_N];
   logic [2:0]        s1_dir [TANK_N];

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_inb  <= 1'b0;
         s1_bhit <= 1'b0;
         s1_whit <= 1'b0;
         s1_thit <= '0;
         for (int i = 0; i < TANK_N; i++) begin
            s1_rx[i] <= '0; s1_ry[i] <= '0; s1_dir[i] <= '0;
         end
      end else begin
         s1_inb  <= in_b;
         s1_bhit <= |b_hit;
         s1_whit <= wall_map[w_row][w_col];
         s1_thit <= t_hit;
         for (int i = 0; i < TANK_N; i++) begin
            s1_rx[i] <= t_rx[i]; s1_ry[i] <= t_ry[i]; s1_dir[i] <= lv_td[i];
         end
      end
   end

   // ---------------- stage 2: priority resolve and sprite offset ----------------
   logic [4:0] sel_rx, sel_ry;
   logic [2:0] sel_dir;
   logic       sel_player, is_tank;
   logic [3:0] cat_n;

   // Scan high to low so the lowest hitting slot wins.
   always_comb begin
      sel_rx     = '0;
      sel_ry     = '0;
      sel_dir    = '0;
      sel_player = 1'b0;
      for (int i = TANK_N - 1; i >= 0; i--) begin
         if (s1_thit[i]) begin
            sel_rx     = s1_rx[i];
            sel_ry     = s1_ry[i];
            sel_dir    = s1_dir[i];
            sel_player = (i == 0);
         end
      end
   end

   assign is_tank = s1_inb && !s1_bhit && (|s1_thit);

   always_comb begin
      cat_n = CAT_NONE;
      if (s1_inb) begin
         if (s1_bhit)       cat_n = CAT_BULLET;
         else if (|s1_thit) cat_n = CAT_TANK;
         else if (s1_whit)  cat_n = CAT_WALL;
      end
   end

   logic [3:0] s2_cat, s3_cat, s4_cat;
   logic       s2_tank, s3_tank;
   logic [9:0] s2_addr;
   logic [2:0] s2_dir, s3_dir;
   logic       s2_player, s3_player;

   // Outputs are staggered so each lines up with its downstream consumer.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_cat <= '0; s2_tank <= 1'b0; s2_addr <= '0; s2_dir <= '0; s2_player <= 1'b0;
         s3_cat <= '0; s3_tank <= 1'b0; s3_dir <= '0; s3_player <= 1'b0;
         s4_cat <= '0;
         addr        <= '0;
         tank_direct <= '0;
         player_tank <= 1'b0;
         category    <= '0;
      end else begin
         s2_cat    <= cat_n;
         s2_tank   <= is_tank;
         s2_addr   <= is_tank ? {sel_ry, sel_rx} : 10'd0;
         s2_dir    <= sel_dir;
         s2_player <= is_tank && sel_player;

         addr      <= s2_addr;
         s3_cat    <= s2_cat;
         s3_tank   <= s2_tank;
         s3_dir    <= s2_dir;
         s3_player <= s2_player;

         if (s3_tank) tank_direct <= s3_dir;   // non-tank pixels keep the last direction
         player_tank <= s3_player;
         s4_cat      <= s3_cat;

         category <= s4_cat;
      end
   end

endmodule
